// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetch/valid/halt sequencer with PC update on accept.
// Optional fetch-wait timeout enabled with macro FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0040_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imemAddr,
  output logic        imemReq,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        instrValid,
  input  logic        instrAccept,
  input  logic        isJmp,
  input  logic        isBeq,
  input  logic        isBne,
  input  logic        invOpcode,
  input  logic        aluZero,
  output logic        halted,
  output logic        fetchErr
);

  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;

  logic [31:0] pc4_c, br_tgt_c, jmp_tgt_c, next_pc_c;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TO_LIMIT = (TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W    = $clog2(TO_LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             to_hit_c;

  // This wait cycle is the one that reaches the limit.
  assign to_hit_c = (32'(cnt_q) + 32'd1) >= TO_LIMIT;
`else
  // Timeout limit has no effect in this build; the empty block keeps it referenced.
  if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
  end
`endif

  // Next-PC selection, priority jump > beq > bne > sequential.
  always_comb begin
    pc4_c     = pc_q + PC_STEP;
    br_tgt_c  = pc4_c + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    jmp_tgt_c = {pc4_c[31:28], instr_q[25:0], 2'b00};
    if (isJmp) begin
      next_pc_c = jmp_tgt_c;
    end else if ((isBeq && aluZero) || (isBne && !aluZero)) begin
      next_pc_c = br_tgt_c;
    end else begin
      next_pc_c = pc4_c;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    req_d    = 1'b0;
    valid_d  = 1'b0;
    halted_d = halted_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d    = '0;
    err_d    = err_q;
`endif
    unique case (state_q)
      S_FETCH: begin
        req_d = 1'b1;
        // Only a response to an issued request is taken.
        if (req_q && imemReady) begin
          instr_d = imemData;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = S_VALID;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (req_q) begin
          if (to_hit_c) begin
            state_d  = S_HALT;
            req_d    = 1'b0;
            halted_d = 1'b1;
            err_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
      end
      S_VALID: begin
        valid_d = 1'b1;
        if (instrAccept) begin
          valid_d = 1'b0;
          if (invOpcode) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            pc_d    = next_pc_c;
            req_d   = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_HALT: begin
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= PC_INIT;
      instr_q  <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign fetchErr = err_q;
`else
  assign fetchErr = 1'b0;
`endif

  assign imemAddr   = pc_q;
  assign pc         = pc_q;
  assign instr      = instr_q;
  assign imemReq    = req_q;
  assign instrValid = valid_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a transaction-level PC model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam int unsigned TO     = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imemAddr;
  logic        imemReq;
  logic        imemReady = 1'b0;
  logic [31:0] imemData = '0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instrValid;
  logic        instrAccept = 1'b0;
  logic        isJmp = 1'b0, isBeq = 1'b0, isBne = 1'b0, invOpcode = 1'b0, aluZero = 1'b0;
  logic        halted;
  logic        fetchErr;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .imemAddr(imemAddr), .imemReq(imemReq), .imemReady(imemReady), .imemData(imemData),
    .instr(instr), .pc(pc), .instrValid(instrValid), .instrAccept(instrAccept),
    .isJmp(isJmp), .isBeq(isBeq), .isBne(isBne), .invOpcode(invOpcode), .aluZero(aluZero),
    .halted(halted), .fetchErr(fetchErr)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural next-PC rule computed with plain integer arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ins,
                                           input logic j, input logic beq, input logic bne,
                                           input logic z);
    longint unsigned p4;
    longint          off;
    p4  = (longint'(cur) + 4) % 64'h1_0000_0000;
    off = longint'($signed(ins[15:0])) * 4;
    if (j) return (32'(p4) & 32'hF000_0000) | (32'(ins[25:0]) * 4);
    if ((beq && z) || (bne && !z)) return 32'((longint'(p4) + off + 64'h1_0000_0000) % 64'h1_0000_0000);
    return 32'(p4);
  endfunction

  task automatic rand_ctrl();
    isJmp = 1'($urandom); isBeq = 1'($urandom); isBne = 1'($urandom);
    invOpcode = 1'($urandom); aluZero = 1'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imemReady = 1'b1;
    imemData = $urandom;
    instrAccept = 1'b1;
    @(negedge clk);
    check_val("rst_pc", pc, RST_PC);
    check_val("rst_instr", instr, 32'h0);
    check_val("rst_valid", 32'(instrValid), 32'h0);
    check_val("rst_req", 32'(imemReq), 32'h0);
    check_val("rst_halted", 32'(halted), 32'h0);
    check_val("rst_err", 32'(fetchErr), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_req", 32'(imemReq), 32'h1);
    check_val("post_rst_discard", 32'(instrValid), 32'h0);
    imemReady = 1'b0;
    instrAccept = 1'b0;
    m_pc = RST_PC;
  endtask

  // One fetch/decode transaction starting at a negedge with a request outstanding.
  task automatic do_txn(input logic [31:0] data, input int nwait, input int nhold,
                        input logic j, input logic beq, input logic bne,
                        input logic inv, input logic z);
    check_val("txn_req", 32'(imemReq), 32'h1);
    check_val("txn_addr", imemAddr, m_pc);
    for (int k = 0; k < nwait; k++) begin
      imemReady = 1'b0;
      imemData = $urandom;
      instrAccept = 1'($urandom);
      @(negedge clk);
      check_val("wait_req", 32'(imemReq), 32'h1);
      check_val("wait_valid", 32'(instrValid), 32'h0);
    end
    imemReady = 1'b1;
    imemData = data;
    instrAccept = 1'($urandom);
    @(negedge clk);
    imemReady = 1'($urandom);
    imemData = $urandom;
    check_val("got_valid", 32'(instrValid), 32'h1);
    check_val("got_req", 32'(imemReq), 32'h0);
    check_val("got_instr", instr, data);
    check_val("got_pc", pc, m_pc);
    for (int k = 0; k < nhold; k++) begin
      instrAccept = 1'b0;
      rand_ctrl();
      @(negedge clk);
      check_val("hold_instr", instr, data);
      check_val("hold_pc", pc, m_pc);
      check_val("hold_valid", 32'(instrValid), 32'h1);
    end
    isJmp = j; isBeq = beq; isBne = bne; invOpcode = inv; aluZero = z;
    instrAccept = 1'b1;
    @(negedge clk);
    instrAccept = 1'b0;
    imemReady = 1'b0;
    rand_ctrl();
    if (inv) begin
      check_val("inv_halted", 32'(halted), 32'h1);
      check_val("inv_req", 32'(imemReq), 32'h0);
      check_val("inv_valid", 32'(instrValid), 32'h0);
      check_val("inv_pc", pc, m_pc);
    end else begin
      m_pc = ref_next(m_pc, data, j, beq, bne, z);
      check_val("next_req", 32'(imemReq), 32'h1);
      check_val("next_addr", imemAddr, m_pc);
      check_val("next_valid", 32'(instrValid), 32'h0);
      check_val("next_halted", 32'(halted), 32'h0);
    end
  endtask

  initial begin
    do_reset();

    // Zero-wait fetch right after reset
    do_txn(32'h2008_0005, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) do_txn($urandom, 0, 0, 0, 0, 0, 0, 0);
    check_val("seq_pc", pc, 32'h0040_0010);
    do_txn({16'h1234, 16'hFFFC}, 0, 0, 0, 1, 0, 0, 1);
    check_val("beq_taken", imemAddr, 32'h0040_0004);
    repeat (3) do_txn($urandom, 0, 0, 0, 0, 0, 0, 0);
    do_txn({16'h1234, 16'hFFFC}, 0, 0, 0, 1, 0, 0, 0);
    check_val("beq_not_taken", imemAddr, 32'h0040_0014);
    do_txn({6'h02, 26'h010_0002}, 0, 0, 1, 0, 0, 0, 0);
    check_val("jmp_to_8", imemAddr, 32'h0040_0008);
    do_txn({6'h02, 26'h010_0000}, 0, 0, 1, 0, 1, 0, 0);
    check_val("jmp_over_bne", imemAddr, 32'h0040_0000);
    do_txn($urandom, 3, 5, 0, 0, 0, 0, 0);

    // Address wrap through zero
    do_txn({6'h02, 26'h0}, 0, 0, 1, 0, 0, 0, 0);
    check_val("jmp_zero", imemAddr, 32'h0);
    do_txn({16'h0, 16'hFFFE}, 0, 0, 0, 1, 0, 0, 1);
    check_val("wrap_down", imemAddr, 32'hFFFF_FFFC);
    do_txn($urandom, 0, 0, 0, 0, 0, 0, 0);
    check_val("wrap_up", imemAddr, 32'h0);

    // Long memory stall
    imemReady = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
      check_val("to_halted", 32'(halted), 32'(i >= int'(TO)));
      check_val("to_err", 32'(fetchErr), 32'(i >= int'(TO)));
`else
      check_val("stall_err", 32'(fetchErr), 32'h0);
      check_val("stall_req", 32'(imemReq), 32'h1);
`endif
    end
    do_reset();

    // Invalid opcode halts until reset
    do_txn($urandom, 1, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      imemReady = 1'b1;
      instrAccept = 1'b1;
      invOpcode = 1'($urandom);
      @(negedge clk);
      check_val("halt_stay", 32'(halted), 32'h1);
      check_val("halt_req", 32'(imemReq), 32'h0);
      check_val("halt_valid", 32'(instrValid), 32'h0);
      check_val("halt_pc", pc, m_pc);
    end
    instrAccept = 1'b0;
    do_reset();

    // Asynchronous reset mid-fetch
    repeat (2) do_txn($urandom, 0, 0, 0, 0, 0, 0, 0);
    imemReady = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_pc", pc, RST_PC);
    check_val("async_rst_req", 32'(imemReq), 32'h0);
    do_reset();

    // Randomized transactions
    for (int t = 0; t < 300; t++) begin
      logic j, beq, bne, inv, z;
      j   = ($urandom % 8) == 0;
      beq = 1'($urandom);
      bne = 1'($urandom);
      z   = 1'($urandom);
      inv = ($urandom % 40) == 0;
      do_txn($urandom, int'($urandom % 4), int'($urandom % 3), j, beq, bne, inv, z);
      if (inv) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
